// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared state encoding and access-size codes for the
//                memory-access sequencer and its lane-merge helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  // Sequencer states, 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Access size codes; 2'b11 is reserved and always rejected
  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mem_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lane_merge
//  Description : Combinational little-endian lane logic: load extraction with
//                sign/zero extension, store read-modify-write merge, and the
//                alignment check for an incoming request.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [1:0]  chk_size_i,
  input  logic [1:0]  chk_addr_lo_i,
  output logic        misaligned_o,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Alignment check on the live request (decided while still in IDLE)
  always_comb begin
    misaligned_o = 1'b0;
    case (chk_size_i)
      SIZE_WORD: misaligned_o = |chk_addr_lo_i;
      SIZE_HALF: misaligned_o = chk_addr_lo_i[0];
      SIZE_BYTE: misaligned_o = 1'b0;
      default:   misaligned_o = 1'b1;
    endcase
  end

  // Extract the addressed lane and extend it to 32 bits
  always_comb begin
    byte_sel    = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel    = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = word_i;
    case (size_i)
      SIZE_HALF: load_data_o = {{16{sext_i & half_sel[15]}}, half_sel};
      SIZE_BYTE: load_data_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      default:   load_data_o = word_i;
    endcase
  end

  // Replace only the addressed lane; every other bit comes from the read word
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SIZE_HALF: begin
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      SIZE_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      default:   merged_o = wdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Memory-access sequencer for the multicycle datapath. Drives a
//                word-wide, 1-cycle-latency synchronous memory, performs
//                sub-word loads, read-modify-write sub-word stores and
//                alignment checking with an addr_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        sext_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_wdata_q;

  logic        misaligned;
  logic        accept;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = (state_q == IDLE) && req;

  mem_lane_merge u_lane (
    .chk_size_i    (size),
    .chk_addr_lo_i (addr[1:0]),
    .misaligned_o  (misaligned),
    .size_i        (size_q),
    .addr_lo_i     (addr_q[1:0]),
    .sext_i        (sext_q),
    .word_i        (mem_rdata),
    .wdata_i       (wdata_q),
    .load_data_o   (load_data),
    .merged_o      (merged)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request latches, loaded only when a request is accepted in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      size_q  <= SIZE_WORD;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= addr;
      size_q  <= size;
      we_q    <= we;
      sext_q  <= sext;
      wdata_q <= wdata;
    end
  end

  // Load result and write word; the merge is taken straight from the memory
  // read data in RWAIT so the write word is ready on entry to WR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q     <= '0;
      mem_wdata_q <= '0;
    end else if (state_q == RWAIT) begin
      if (we_q) mem_wdata_q <= merged;
      else      rdata_q     <= load_data;
    end else if (accept && we && (size == SIZE_WORD) && !misaligned) begin
      mem_wdata_q <= wdata;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (misaligned)                    state_d = ERR;
          else if (we && size == SIZE_WORD)  state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = RWAIT;
      RWAIT:   state_d = we_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the state register or taken from registers
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign addr_err  = (state_q == ERR);
  assign mem_wr    = (state_q == WR);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access sequencer downstream of the IorD address multiplexer in the multicycle datapath. Takes the selected 32-bit address together with a size/direction request from the control unit and runs the cycle sequence against the word-wide, 1-cycle-latency synchronous memory. It also performs sub-word load extraction and extension, read-modify-write for byte and halfword stores, and alignment checking, which raises `addr_err` for the exception path.

## Interface
- Parameters: none. Memory width is fixed at 32 bits and byte order is fixed little-endian.
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  1  start an access; sampled only in IDLE
- `we`  in  1  0 = load, 1 = store
- `size`  in  2  00 word, 01 half, 10 byte, 11 reserved (error)
- `sext`  in  1  loads only: 1 = sign-extend sub-word, 0 = zero-extend
- `addr`  in  32  byte address, driven from the IorD mux output
- `wdata`  in  32  store data; half uses [15:0], byte uses [7:0]
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the access completes
- `addr_err`  out  1  one-cycle pulse, coincident with `done`, when the access was rejected
- `rdata`  out  32  load result; held until the next successful load completes
- `mem_addr`  out  32  word-aligned address {addr_q[31:2], 2'b00}
- `mem_wr`  out  1  memory write strobe
- `mem_wdata`  out  32  full word to write
- `mem_rdata`  in  32  memory read data, valid one cycle after `mem_addr` is presented with `mem_wr`=0

## Operation
- In IDLE with `req`=1, latch `addr`, `size`, `we`, `sext` and `wdata`. Then select the next state:
  - Misaligned request goes to ERR. Misaligned means: size 11; word with addr[1:0]≠0; half with addr[0]=1.
  - Word store goes to WR.
  - All other requests go to RD.
- RD: drive `mem_addr`, `mem_wr`=0, then go to RWAIT.
- RWAIT: `mem_rdata` is valid; capture it into `word_q`.
  - Load: compute the result, then go to DONE.
  - Sub-word store: merge the new data into the captured word, then go to WR.
- WR: `mem_wr`=1; `mem_wdata` is the merged word (or `wdata_q` for a word store). Then go to DONE.
- DONE: `done`=1; `rdata` is updated at entry on loads only. Then go to IDLE.
- ERR: `done`=1 and `addr_err`=1; no memory access occurs and `rdata` is unchanged. Then go to IDLE.
- Lane rules (little-endian):
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane addr[1] selects [15:0] or [31:16].
  - Extension uses bit 7 or bit 15 of the extracted value when `sext`=1.
  - A store merge replaces only the addressed lane; all other bits come from `word_q`.
- `req` is ignored while `busy`=1.
- `mem_wr` is asserted only in WR, for exactly one cycle per store.

## Timing
- Reset values: state IDLE; `busy`=0, `done`=0, `addr_err`=0, `rdata`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req` to any output.
- Latency, counted from the cycle in which `req` is sampled (cycle 0) to the cycle with `done`=1:
  - Error: 1 cycle.
  - Word store: 2 cycles.
  - Load of any size: 3 cycles.
  - Byte/half store: 4 cycles.
- The earliest next `req` is accepted in the cycle after `done`, when the unit is back in IDLE.
- `addr`, `wdata` and the other request inputs may change after cycle 0, because they are latched.
- Reset asserted mid-operation: all outputs return to their reset values immediately and asynchronously. The memory write is either completed or not performed; a write is never partial, because `mem_wr` is a single cycle.

## Structure
- Shared package `mem_access_pkg` contains:
  - State encoding: IDLE, RD, RWAIT, WR, DONE, ERR (3 bits).
  - Size codes: SIZE_WORD, SIZE_HALF, SIZE_BYTE.
- One sub-module, `mem_lane_merge` (purely combinational), performs:
  - Extract plus extension for loads.
  - Lane merge for stores.
  - Misalignment detect.
- The top level contains the FSM and the request latches.

## Test plan
- Load byte: memory word at 0x10 = 0x8844_22F1, `addr`=0x13, `sext`=1 → `done` at cycle 3, `rdata`=0xFFFF_FF88, `mem_wr` never asserted.
- Load half, zero-extend: same memory word, `addr`=0x10, `sext`=0 → `rdata`=0x0000_22F1.
- Store byte: memory word at 0x20 = 0x1122_3344, `addr`=0x21, `wdata`=0xAB → single `mem_wr` at cycle 3 with `mem_wdata`=0x1122_AB44, `done` at cycle 4.
- Store word: `addr`=0x40, `wdata`=0xDEAD_BEEF → `mem_wr` at cycle 1 with `mem_addr`=0x40, `done` at cycle 2, no read cycle.
- Misaligned requests (half at 0x31, word at 0x42, size 11) → `done`=`addr_err`=1 at cycle 1, no `mem_wr`, `rdata` unchanged.
- `reset_n` low during RWAIT of a byte store → state IDLE, `mem_wr` never asserted, memory unchanged. A `req` held high while `busy`=1 does not start a second access.
